// File: rtl/work_dispatcher.sv
// Host-side job/solution dispatcher for the mining core: loads a job, streams
// it to the core over the 32-bit word bus, then relays solution claims and verdicts.
module work_dispatcher #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_midstate,
  input  logic [511:0] job_header,
  output logic         result_valid,
  output logic         result_found,
  output logic [31:0]  result_nonce,
  input  logic         result_ready,
  input  logic         result_accept,
  output logic         start_found,
  output logic [31:0]  in_data,
  input  logic         sol_claim,
  input  logic [31:0]  out_data,
  output logic [1:0]   sol_response,
  output logic [2:0]   state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid is held stable by its source until that edge.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    MID     = 3'd2,
    HEAD    = 3'd3,
    SOLVE   = 3'd4,
    REPORT  = 3'd5,
    RESPOND = 3'd6
  } state_t;

  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

  state_t       state, state_nxt;
  logic [255:0] mid_q;
  logic [511:0] head_q;
  logic [3:0]   word_idx;
  logic [31:0]  timeout_cnt;
  logic         timeout_hit;

  assign timeout_hit  = (timeout_cnt == TIMEOUT_LAST);
  assign job_ready    = (state == IDLE) && !rst;
  assign result_valid = (state == REPORT);
  assign state_dbg    = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (job_valid) state_nxt = START;
      START:   state_nxt = MID;
      MID:     if (word_idx == 4'd7) state_nxt = HEAD;
      HEAD:    if (word_idx == 4'd15) state_nxt = SOLVE;
      SOLVE:   if (sol_claim || timeout_hit) state_nxt = REPORT;
      REPORT:  if (result_ready) state_nxt = result_found ? RESPOND : IDLE;
      // sol_response still carries the verdict sent in this cycle
      RESPOND: state_nxt = (sol_response == 2'b01) ? IDLE : SOLVE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mid_q        <= '0;
      head_q       <= '0;
      word_idx     <= '0;
      timeout_cnt  <= '0;
      result_found <= 1'b0;
      result_nonce <= '0;
      start_found  <= 1'b0;
      in_data      <= '0;
      sol_response <= 2'b00;
    end else begin
      state        <= state_nxt;
      start_found  <= 1'b0;
      sol_response <= 2'b00;
      case (state)
        IDLE: begin
          in_data <= '0;
          if (job_valid) begin
            mid_q       <= job_midstate;
            head_q      <= job_header;
            timeout_cnt <= '0;
            start_found <= 1'b1;
          end
        end
        // Words are shifted out of the top of the job registers so the
        // next word to send is always in the most-significant slot.
        START: begin
          word_idx <= '0;
          in_data  <= mid_q[255:224];
          mid_q    <= {mid_q[223:0], 32'h0};
        end
        MID: begin
          if (word_idx == 4'd7) begin
            word_idx <= '0;
            in_data  <= head_q[511:480];
            head_q   <= {head_q[479:0], 32'h0};
          end else begin
            word_idx <= word_idx + 4'd1;
            in_data  <= mid_q[255:224];
            mid_q    <= {mid_q[223:0], 32'h0};
          end
        end
        HEAD: begin
          if (word_idx == 4'd15) begin
            in_data <= '0;
          end else begin
            word_idx <= word_idx + 4'd1;
            in_data  <= head_q[511:480];
            head_q   <= {head_q[479:0], 32'h0};
          end
        end
        SOLVE: begin
          in_data     <= '0;
          timeout_cnt <= timeout_cnt + 32'd1;
          // A claim in the match cycle takes priority over the abort
          if (sol_claim) begin
            result_found <= 1'b1;
            result_nonce <= out_data;
          end else if (timeout_hit) begin
            result_found <= 1'b0;
            result_nonce <= '0;
            sol_response <= 2'b11;
          end
        end
        REPORT: begin
          if (result_ready && result_found)
            sol_response <= result_accept ? 2'b01 : 2'b10;
        end
        RESPOND: begin
          if (sol_response == 2'b01) timeout_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_work_dispatcher.sv
// Directed bench for work_dispatcher: job streaming, verdict relay, timeout
// abort, claim/timeout tie and reset in the middle of a job.
module tb_work_dispatcher;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_SOLVE   = 3'd4;
  localparam logic [2:0] S_REPORT  = 3'd5;
  localparam logic [2:0] S_RESPOND = 3'd6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [255:0] job_midstate = '0;
  logic [511:0] job_header = '0;
  logic         result_valid;
  logic         result_found;
  logic [31:0]  result_nonce;
  logic         result_ready = 1'b0;
  logic         result_accept = 1'b0;
  logic         start_found;
  logic [31:0]  in_data;
  logic         sol_claim = 1'b0;
  logic [31:0]  out_data = '0;
  logic [1:0]   sol_response;
  logic [2:0]   state_dbg;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_words [24];

  work_dispatcher #(.TIMEOUT_CYCLES(32'd100)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_midstate(job_midstate), .job_header(job_header),
    .result_valid(result_valid), .result_found(result_found),
    .result_nonce(result_nonce), .result_ready(result_ready),
    .result_accept(result_accept), .start_found(start_found),
    .in_data(in_data), .sol_claim(sol_claim), .out_data(out_data),
    .sol_response(sol_response), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads the 24 test-plan words into the job buses and the expected table.
  task automatic load_pattern(input logic [31:0] base_mid, input logic [31:0] base_head);
    for (int i = 0; i < 8; i++) begin
      exp_words[i] = base_mid * (i + 1);
      job_midstate[255 - 32*i -: 32] = exp_words[i];
    end
    for (int i = 0; i < 16; i++) begin
      exp_words[8 + i] = base_head + i;
      job_header[511 - 32*i -: 32] = exp_words[8 + i];
    end
  endtask

  // Handshake then stream; returns in the first SOLVE cycle.
  task automatic run_job();
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    repeat (25) tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if ({job_ready, result_valid, result_found, result_nonce, start_found, in_data, sol_response} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: rdy=%b rv=%b rf=%b nonce=%h sf=%b data=%h resp=%b, required all 0",
               job_ready, result_valid, result_found, result_nonce, start_found, in_data, sol_response);
    end
    tests++;
    if (state_dbg !== S_IDLE) begin
      fails++;
      $display("FAIL reset_state: got %0d required %0d", state_dbg, S_IDLE);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (job_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b required 1", job_ready);
    end
  endtask

  task automatic test_serialise();
    load_pattern(32'h11111111, 32'hA0000000);
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    tests++;
    if (start_found !== 1'b1 || in_data !== 32'h0 || job_ready !== 1'b0) begin
      fails++;
      $display("FAIL ser_start: sf=%b data=%h rdy=%b required sf=1 data=0 rdy=0", start_found, in_data, job_ready);
    end
    for (int i = 0; i < 24; i++) begin
      tick();
      tests++;
      if (in_data !== exp_words[i] || start_found !== 1'b0) begin
        fails++;
        $display("FAIL ser_word%0d: data=%h sf=%b required data=%h sf=0", i, in_data, start_found, exp_words[i]);
      end
    end
    tick();
    tests++;
    if (in_data !== 32'h0 || state_dbg !== S_SOLVE) begin
      fails++;
      $display("FAIL ser_end: data=%h state=%0d required data=0 state=%0d", in_data, state_dbg, S_SOLVE);
    end
  endtask

  task automatic test_accept();
    load_pattern(32'h01010101, 32'hB0000000);
    run_job();
    repeat (5) tick();
    sol_claim = 1'b1; out_data = 32'hDEADBEEF;
    result_ready = 1'b1; result_accept = 1'b1;
    tick();
    tests++;
    if (result_valid !== 1'b1 || result_found !== 1'b1 || result_nonce !== 32'hDEADBEEF || sol_response !== 2'b00) begin
      fails++;
      $display("FAIL acc_report: rv=%b rf=%b nonce=%h resp=%b required 1 1 deadbeef 00",
               result_valid, result_found, result_nonce, sol_response);
    end
    tick();
    tests++;
    if (sol_response !== 2'b01 || state_dbg !== S_RESPOND) begin
      fails++;
      $display("FAIL acc_resp: resp=%b state=%0d required 01 %0d", sol_response, state_dbg, S_RESPOND);
    end
    sol_claim = 1'b0;
    tick();
    tests++;
    if (sol_response !== 2'b00 || state_dbg !== S_IDLE || job_ready !== 1'b1) begin
      fails++;
      $display("FAIL acc_idle: resp=%b state=%0d rdy=%b required 00 %0d 1", sol_response, state_dbg, job_ready, S_IDLE);
    end
    result_ready = 1'b0;
  endtask

  task automatic test_reject_resume();
    run_job();
    tick();
    sol_claim = 1'b1; out_data = 32'h00000001;
    result_ready = 1'b1; result_accept = 1'b0;
    tick();
    tests++;
    if (result_nonce !== 32'h1 || result_found !== 1'b1 || result_valid !== 1'b1) begin
      fails++;
      $display("FAIL rej_report: nonce=%h rf=%b rv=%b required 00000001 1 1", result_nonce, result_found, result_valid);
    end
    tick();
    tests++;
    if (sol_response !== 2'b10) begin
      fails++;
      $display("FAIL rej_resp: got %b required 10", sol_response);
    end
    sol_claim = 1'b0;
    tick();
    tests++;
    if (sol_response !== 2'b00 || state_dbg !== S_SOLVE) begin
      fails++;
      $display("FAIL rej_resume: resp=%b state=%0d required 00 %0d", sol_response, state_dbg, S_SOLVE);
    end
    tick();
    sol_claim = 1'b1; out_data = 32'h00000002; result_accept = 1'b1;
    tick();
    tests++;
    if (result_nonce !== 32'h2 || result_valid !== 1'b1) begin
      fails++;
      $display("FAIL rej_second_report: nonce=%h rv=%b required 00000002 1", result_nonce, result_valid);
    end
    tick();
    tests++;
    if (sol_response !== 2'b01) begin
      fails++;
      $display("FAIL rej_second_resp: got %b required 01", sol_response);
    end
    sol_claim = 1'b0;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_timeout();
    run_job();
    repeat (99) tick();
    tests++;
    if (state_dbg !== S_SOLVE || sol_response !== 2'b00 || result_valid !== 1'b0) begin
      fails++;
      $display("FAIL to_early: state=%0d resp=%b rv=%b required %0d 00 0", state_dbg, sol_response, result_valid, S_SOLVE);
    end
    tick();
    tests++;
    if (sol_response !== 2'b11 || result_valid !== 1'b1 || result_found !== 1'b0 || result_nonce !== 32'h0) begin
      fails++;
      $display("FAIL to_abort: resp=%b rv=%b rf=%b nonce=%h required 11 1 0 0",
               sol_response, result_valid, result_found, result_nonce);
    end
    tick();
    tests++;
    if (sol_response !== 2'b00 || result_valid !== 1'b1) begin
      fails++;
      $display("FAIL to_hold: resp=%b rv=%b required 00 1", sol_response, result_valid);
    end
    result_ready = 1'b1; result_accept = 1'b1;
    tick();
    tests++;
    if (state_dbg !== S_IDLE || sol_response !== 2'b00) begin
      fails++;
      $display("FAIL to_idle: state=%0d resp=%b required %0d 00", state_dbg, sol_response, S_IDLE);
    end
    result_ready = 1'b0;
  endtask

  task automatic test_reject_keeps_count();
    int n;
    run_job();
    tick();
    sol_claim = 1'b1; out_data = 32'h00000055;
    result_ready = 1'b1; result_accept = 1'b0;
    tick();
    tick();
    sol_claim = 1'b0;
    result_ready = 1'b0;
    n = 2;
    while (n < 200 && sol_response !== 2'b11) begin
      tick();
      n++;
    end
    tests++;
    if (n != 101 && n != 102) begin
      fails++;
      $display("FAIL rej_count_abort: abort %0d cycles after claim, required 101 or 102", n);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_tie();
    run_job();
    repeat (99) tick();
    sol_claim = 1'b1; out_data = 32'hCAFE0001;
    result_ready = 1'b1; result_accept = 1'b1;
    tick();
    tests++;
    if (sol_response !== 2'b00 || result_found !== 1'b1 || result_nonce !== 32'hCAFE0001 || result_valid !== 1'b1) begin
      fails++;
      $display("FAIL tie_report: resp=%b rf=%b nonce=%h rv=%b required 00 1 cafe0001 1",
               sol_response, result_found, result_nonce, result_valid);
    end
    tick();
    tests++;
    if (sol_response !== 2'b01) begin
      fails++;
      $display("FAIL tie_resp: got %b required 01", sol_response);
    end
    sol_claim = 1'b0;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    load_pattern(32'h02020202, 32'hC0000000);
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    repeat (16) tick();
    tests++;
    if (in_data !== 32'hC0000007) begin
      fails++;
      $display("FAIL rst_mid_word7: got %h required c0000007", in_data);
    end
    rst = 1'b1;
    tick();
    tests++;
    if ({job_ready, result_valid, start_found, in_data, sol_response} !== '0 || state_dbg !== S_IDLE) begin
      fails++;
      $display("FAIL rst_mid_clear: rdy=%b rv=%b sf=%b data=%h resp=%b state=%0d required all 0",
               job_ready, result_valid, start_found, in_data, sol_response, state_dbg);
    end
    rst = 1'b0;
    load_pattern(32'h03030303, 32'hD0000000);
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    tests++;
    if (start_found !== 1'b1 || state_dbg !== S_START) begin
      fails++;
      $display("FAIL rst_new_start: sf=%b state=%0d required 1 %0d", start_found, state_dbg, S_START);
    end
    for (int i = 0; i < 24; i++) begin
      tick();
      if (i == 0 || i == 8 || i == 23) begin
        tests++;
        if (in_data !== exp_words[i]) begin
          fails++;
          $display("FAIL rst_new_word%0d: got %h required %h", i, in_data, exp_words[i]);
        end
      end
    end
    pulse_reset();
  endtask

  initial begin
    test_reset();
    test_serialise();
    pulse_reset();
    test_accept();
    test_reject_resume();
    test_timeout();
    test_reject_keeps_count();
    test_tie();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
